receptor_serial: RTL and testbench

Serial-to-parallel receiver that sits directly upstream of the 7-segment `Display` stage. It samples a single asynchronous serial line carrying 5-bit values with a parity bit and presents each received word on `Valores`/`Paridade`. `Display` consumes those outputs to check parity (`Validade`) and drive `Segmentos`. The block passes the received parity bit through unchanged; parity checking belongs to `Display`.

---
 rtl/receptor_serial_pkg.sv | 15 +
 rtl/receptor_serial_sincronizador.sv | 21 ++
 rtl/receptor_serial.sv | 133 +++++++++++++
 tb/tb_receptor_serial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/receptor_serial_pkg.sv
// Shared definitions for the serial receiver: frame geometry and FSM state encoding.
package pacote_serial;

    localparam int BITS_DADOS  = 5;
    localparam int BITS_QUADRO = 8;

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

endpackage

// File: rtl/receptor_serial_sincronizador.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module sincronizador (
    input  logic Clock,
    input  logic Reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/receptor_serial.sv
// Serial receiver: start bit, 5 data bits LSB first, parity, stop bit; presents each
// correctly framed word on Valores/Paridade with a Pronto pulse, or pulses Erro.
module receptor_serial
    import pacote_serial::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Dado,
    output logic [4:0] Valores,
    output logic       Paridade,
    output logic       Pronto,
    output logic       Erro
);

    localparam int CW = $clog2(CICLOS_POR_BIT) + 1;
    localparam logic [CW-1:0] MEIO_FIM = CW'(CICLOS_POR_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_FIM  = CW'(CICLOS_POR_BIT - 1);
    localparam logic [2:0]    ULTIMO_DADO = 3'(BITS_DADOS - 1);

    logic dado_s;

    estado_t                 estado_q, estado_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2:0]              nbits_q, nbits_d;
    logic [BITS_DADOS-1:0]   desloc_q, desloc_d;
    logic                    par_q, par_d;
    logic [BITS_DADOS-1:0]   valores_q, valores_d;
    logic                    paridade_q, paridade_d;
    logic                    pronto_q, pronto_d;
    logic                    erro_q, erro_d;

    sincronizador u_sincronizador (
        .Clock (Clock),
        .Reset (Reset),
        .d_i   (Dado),
        .q_o   (dado_s)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            nbits_q    <= '0;
            desloc_q   <= '0;
            par_q      <= 1'b0;
            valores_q  <= '0;
            paridade_q <= 1'b0;
            pronto_q   <= 1'b0;
            erro_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            nbits_q    <= nbits_d;
            desloc_q   <= desloc_d;
            par_q      <= par_d;
            valores_q  <= valores_d;
            paridade_q <= paridade_d;
            pronto_q   <= pronto_d;
            erro_q     <= erro_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q + CW'(1);
        nbits_d    = nbits_q;
        desloc_d   = desloc_q;
        par_d      = par_q;
        valores_d  = valores_q;
        paridade_d = paridade_q;
        pronto_d   = 1'b0;
        erro_d     = 1'b0;

        case (estado_q)
            OCIOSO: begin
                cnt_d = '0;
                if (!dado_s) begin
                    estado_d = INICIO;
                end
            end
            INICIO: begin
                // Half-bit wait lands subsequent samples near the middle of each bit.
                if (cnt_q == MEIO_FIM) begin
                    cnt_d    = '0;
                    nbits_d  = '0;
                    estado_d = dado_s ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (cnt_q == BIT_FIM) begin
                    cnt_d    = '0;
                    desloc_d = {dado_s, desloc_q[BITS_DADOS-1:1]};
                    nbits_d  = nbits_q + 3'd1;
                    if (nbits_q == ULTIMO_DADO) begin
                        estado_d = PARIDADE;
                    end
                end
            end
            PARIDADE: begin
                if (cnt_q == BIT_FIM) begin
                    cnt_d    = '0;
                    par_d    = dado_s;
                    estado_d = PARADA;
                end
            end
            PARADA: begin
                if (cnt_q == BIT_FIM) begin
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                    if (dado_s) begin
                        valores_d  = desloc_q;
                        paridade_d = par_q;
                        pronto_d   = 1'b1;
                    end else begin
                        erro_d = 1'b1;
                    end
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase
    end

    assign Valores  = valores_q;
    assign Paridade = paridade_q;
    assign Pronto   = pronto_q;
    assign Erro     = erro_q;

endmodule

// File: tb/tb_receptor_serial.sv
// Self-checking bench for receptor_serial: directed scenarios plus random frames,
// checked every cycle against a queue of expected output events.
module tb_receptor_serial;

    localparam int N = 4;
    // Dado falls -> 2 sync cycles -> 1 cycle to leave OCIOSO -> half bit -> 7 bit periods.
    localparam int LATENCIA = 3 + N / 2 + 7 * N;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Dado;
    logic [4:0] Valores;
    logic       Paridade;
    logic       Pronto;
    logic       Erro;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         quando;
        bit         ok;
        logic [4:0] val;
        logic       par;
    } evento_t;

    evento_t    esperado_q[$];
    evento_t    ev;
    logic [4:0] val_model = 5'b0;
    logic       par_model = 1'b0;
    logic       exp_pronto;
    logic       exp_erro;

    receptor_serial #(.CICLOS_POR_BIT(N)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Dado     (Dado),
        .Valores  (Valores),
        .Paridade (Paridade),
        .Pronto   (Pronto),
        .Erro     (Erro)
    );

    always #5 Clock = ~Clock;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Monitor: compares outputs shortly after every rising edge.
    initial begin
        forever begin
            @(posedge Clock);
            cyc++;
            #2;
            exp_pronto = 1'b0;
            exp_erro   = 1'b0;
            if (esperado_q.size() > 0) begin
                verifica("evento_perdido", 32'(esperado_q[0].quando < cyc), 32'd0);
                if (esperado_q[0].quando == cyc) begin
                    ev = esperado_q.pop_front();
                    if (ev.ok) begin
                        exp_pronto = 1'b1;
                        val_model  = ev.val;
                        par_model  = ev.par;
                    end else begin
                        exp_erro = 1'b1;
                    end
                    $display("cycle %0d frame ok=%0d Valores=%b Paridade=%b Pronto=%b Erro=%b",
                             cyc, ev.ok, Valores, Paridade, Pronto, Erro);
                end
            end
            verifica("pronto",   32'(Pronto),   32'(exp_pronto));
            verifica("erro",     32'(Erro),     32'(exp_erro));
            verifica("valores",  32'(Valores),  32'(val_model));
            verifica("paridade", 32'(Paridade), 32'(par_model));
        end
    end

    task automatic espera(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Sends one frame starting at the current negedge; aborta >= 0 resets inside that bit.
    task automatic envia(input logic [4:0] d, input logic p, input logic stop, input int aborta);
        logic [7:0] q;
        evento_t    e;
        q = {stop, p, d, 1'b0};
        e.quando = cyc + LATENCIA;
        e.ok     = stop;
        e.val    = d;
        e.par    = p;
        esperado_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            Dado = q[i];
            if (i == aborta) begin
                espera(1);
                Reset = 1'b1;
                Dado  = 1'b1;
                esperado_q.delete();
                val_model = 5'b0;
                par_model = 1'b0;
                espera(1);
                Reset = 1'b0;
                return;
            end
            espera(N);
        end
        Dado = 1'b1;
    endtask

    task automatic glitch();
        Dado = 1'b0;
        espera(1);
        Dado = 1'b1;
        espera(6);
    endtask

    initial begin
        int         k;
        logic [4:0] d;
        logic       p;
        logic       s;

        Reset = 1'b1;
        Dado  = 1'b1;
        espera(3);
        Reset = 1'b0;
        espera(4);

        envia(5'b00001, 1'b0, 1'b1, -1);
        espera(6);

        envia(5'b00010, 1'b0, 1'b1, -1);
        envia(5'b10101, 1'b1, 1'b1, -1);
        espera(6);

        glitch();

        envia(5'b00001, 1'b0, 1'b1, -1);
        espera(3);
        envia(5'b11111, 1'b1, 1'b0, -1);
        espera(8);

        envia(5'b01010, 1'b0, 1'b1, 4);
        espera(10);
        envia(5'b00011, 1'b1, 1'b1, -1);
        espera(6);

        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                glitch();
            end else begin
                d = 5'($urandom);
                p = 1'($urandom);
                s = (k != 1);
                envia(d, p, s, -1);
                if (s) espera($urandom_range(0, 5));
                else   espera($urandom_range(4, 8));
            end
        end

        espera(LATENCIA + 10);
        verifica("fila_vazia", 32'(esperado_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
